// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the pointer controller.
// Contents:
//   SIDE_WR / SIDE_RD : values of the SIDE parameter (write side / read side)
//   GRAY_MAX_W        : widest vector the helpers operate on
//   bin2gray(b, w)    : binary -> Gray over the low w bits, upper bits cleared
//   gray2bin(g, w)    : Gray -> binary over the low w bits, upper bits cleared
// Callers zero-extend their operand to GRAY_MAX_W and cast the result back
// to their own width, so one pair of functions serves every pointer width.
package gray_pkg;

    localparam int SIDE_WR    = 0;
    localparam int SIDE_RD    = 1;
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] b,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] g;
        g = b ^ (b >> 1);
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            g[i] = (i < w) ? g[i] : 1'b0;
        end
        return g;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] gm;
        logic [GRAY_MAX_W-1:0] b;
        gm = g;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            gm[i] = (i < w) ? g[i] : 1'b0;
        end
        // Binary bit i is the XOR of every Gray bit at or above i.
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = (i < w) ? (^(gm >> i)) : 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decode_reg.sv
// Registered Gray-to-binary decode of the remote pointer.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears bin_q
//   gray_in  : W-bit Gray pointer already synchronised into this domain
//   bin_q    : W-bit binary equivalent, one cycle behind gray_in
module gray_decode_reg
    import gray_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] bin_q
);

    // Decode register: reloaded every cycle from the synchronised Gray value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= {W{1'b0}};
        end else begin
            bin_q <= W'(gray2bin(GRAY_MAX_W'(gray_in), W));
        end
    end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async-FIFO pointer pair: local binary/Gray pointer,
// full or empty flag, almost flag, occupancy estimate and sticky overflow.
// Parameters: AW address width (pointers AW+1 bits), SIDE write(0)/read(1),
//             ALMOST almost-threshold in entries.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   inc        : request to advance the local pointer by one entry
//   rgray_sync : remote Gray pointer, already synchronised into clk
//   ptr_bin    : local binary pointer (registered)
//   ptr_gray   : local Gray pointer (registered, exported to remote domain)
//   addr       : memory address, low AW bits of ptr_bin
//   flag       : full (write side) or empty (read side), registered
//   almost     : almost-full / almost-empty
//   level      : occupancy estimate 0 .. 2^AW
//   ovf_err    : sticky, set by a request while flag is high
module gray_ptr_ctrl
    import gray_pkg::*;
#(
    parameter int AW     = 4,
    parameter int SIDE   = SIDE_WR,
    parameter int ALMOST = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic [AW:0]   rgray_sync,
    output logic [AW:0]   ptr_bin,
    output logic [AW:0]   ptr_gray,
    output logic [AW-1:0] addr,
    output logic          flag,
    output logic          almost,
    output logic [AW:0]   level,
    output logic          ovf_err
);

    localparam int          PW         = AW + 1;
    localparam logic [AW:0] FULL_THR   = PW'((1 << AW) - ALMOST);
    localparam logic [AW:0] ALMOST_THR = PW'(ALMOST);
    localparam logic        FLAG_RST   = (SIDE == SIDE_RD);

    logic        advance_s;
    logic [AW:0] bin_next_s;
    logic [AW:0] gray_next_s;
    logic [AW:0] full_pat_s;
    logic        flag_next_s;
    logic [AW:0] rbin_q;

    // Next pointer and next flag; the flag is judged on the pointer value
    // being loaded this edge against the current remote Gray pointer, so a
    // simultaneous remote change and local advance are both accounted for.
    always_comb begin
        advance_s   = inc & ~flag;
        bin_next_s  = ptr_bin + {{AW{1'b0}}, advance_s};
        gray_next_s = PW'(bin2gray(GRAY_MAX_W'(bin_next_s), PW));
        // Full when the local pointer is exactly one lap ahead: in Gray code
        // that is the remote value with its two top bits inverted.
        full_pat_s  = {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]};
        flag_next_s = (SIDE == SIDE_RD) ? (gray_next_s == rgray_sync)
                                        : (gray_next_s == full_pat_s);
    end

    // Pointer, flag and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_bin  <= {PW{1'b0}};
            ptr_gray <= {PW{1'b0}};
            flag     <= FLAG_RST;
            ovf_err  <= 1'b0;
        end else begin
            ptr_bin  <= bin_next_s;
            ptr_gray <= gray_next_s;
            flag     <= flag_next_s;
            ovf_err  <= ovf_err | (inc & flag);
        end
    end

    gray_decode_reg #(
        .W (PW)
    ) u_decode (
        .clk     (clk),
        .rst     (rst),
        .gray_in (rgray_sync),
        .bin_q   (rbin_q)
    );

    // Occupancy and almost flag, derived from registers only; level may trail
    // the remote pointer by the one cycle of the decode stage.
    always_comb begin
        addr   = ptr_bin[AW-1:0];
        level  = (SIDE == SIDE_RD) ? (rbin_q - ptr_bin) : (ptr_bin - rbin_q);
        almost = (SIDE == SIDE_RD) ? (level <= ALMOST_THR) : (level >= FULL_THR);
    end

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
module tb_gray_ptr_ctrl;

    logic       clk;
    logic       w_rst, w_inc;
    logic [4:0] w_rgray, w_ptr_bin, w_ptr_gray, w_level;
    logic [3:0] w_addr;
    logic       w_flag, w_almost, w_ovf;
    logic       r_rst, r_inc;
    logic [4:0] r_rgray, r_ptr_bin, r_ptr_gray, r_level;
    logic [3:0] r_addr;
    logic       r_flag, r_almost, r_ovf;

    int checks = 0;
    int errors = 0;

    gray_ptr_ctrl #(.AW(4), .SIDE(0), .ALMOST(2)) u_wr (
        .clk(clk), .rst(w_rst), .inc(w_inc), .rgray_sync(w_rgray),
        .ptr_bin(w_ptr_bin), .ptr_gray(w_ptr_gray), .addr(w_addr),
        .flag(w_flag), .almost(w_almost), .level(w_level), .ovf_err(w_ovf)
    );

    gray_ptr_ctrl #(.AW(4), .SIDE(1), .ALMOST(2)) u_rd (
        .clk(clk), .rst(r_rst), .inc(r_inc), .rgray_sync(r_rgray),
        .ptr_bin(r_ptr_bin), .ptr_gray(r_ptr_gray), .addr(r_addr),
        .flag(r_flag), .almost(r_almost), .level(r_level), .ovf_err(r_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        w_rst = 1'b1; w_inc = 1'b0; w_rgray = 5'b00000;
        r_rst = 1'b1; r_inc = 1'b0; r_rgray = 5'b00000;
        tick();
        w_rst = 1'b0; r_rst = 1'b0;

        // Reset state, both sides
        chk("rst_w_ptr_bin", 32'(w_ptr_bin), 32'd0);
        chk("rst_w_ptr_gray", 32'(w_ptr_gray), 32'd0);
        chk("rst_w_ovf", 32'(w_ovf), 32'd0);
        chk("rst_w_flag", 32'(w_flag), 32'd0);
        chk("rst_w_almost", 32'(w_almost), 32'd0);
        chk("rst_w_level", 32'(w_level), 32'd0);
        chk("rst_r_ptr_gray", 32'(r_ptr_gray), 32'd0);
        chk("rst_r_flag", 32'(r_flag), 32'd1);
        chk("rst_r_almost", 32'(r_almost), 32'd1);
        chk("rst_r_level", 32'(r_level), 32'd0);

        // Write side: almost-full then full then blocked request
        w_inc = 1'b1;
        repeat (13) tick();
        chk("af_ptr13", 32'(w_ptr_bin), 32'd13);
        chk("af_level13", 32'(w_level), 32'd13);
        chk("af_almost13", 32'(w_almost), 32'd0);
        tick();
        chk("af_ptr14", 32'(w_ptr_bin), 32'd14);
        chk("af_almost14", 32'(w_almost), 32'd1);
        chk("af_flag14", 32'(w_flag), 32'd0);
        tick();
        chk("full_flag15", 32'(w_flag), 32'd0);
        tick();
        chk("full_ptr16", 32'(w_ptr_bin), 32'd16);
        chk("full_gray16", 32'(w_ptr_gray), 32'b11000);
        chk("full_flag16", 32'(w_flag), 32'd1);
        chk("full_level16", 32'(w_level), 32'd16);
        chk("full_addr16", 32'(w_addr), 32'd0);
        chk("full_ovf_before", 32'(w_ovf), 32'd0);
        tick();
        chk("blk_ptr", 32'(w_ptr_bin), 32'd16);
        chk("blk_gray", 32'(w_ptr_gray), 32'b11000);
        chk("blk_ovf", 32'(w_ovf), 32'd1);
        w_inc = 1'b0;

        // Remote moves to binary 28 (Gray 10010): room until local reaches 12
        w_rgray = 5'b10010;
        tick();
        chk("rel_flag", 32'(w_flag), 32'd0);
        tick();
        chk("rel_level", 32'(w_level), 32'd20);
        w_inc = 1'b1;
        repeat (25) tick();
        chk("mid_ptr9", 32'(w_ptr_bin), 32'd9);
        chk("mid_addr9", 32'(w_addr), 32'd9);
        chk("mid_gray9", 32'(w_ptr_gray), 32'b01101);
        chk("mid_ovf_sticky", 32'(w_ovf), 32'd1);
        chk("mid_flag", 32'(w_flag), 32'd0);
        // Reset mid-operation with inc still high
        w_rst = 1'b1;
        tick();
        chk("mrst_ptr", 32'(w_ptr_bin), 32'd0);
        chk("mrst_gray", 32'(w_ptr_gray), 32'd0);
        chk("mrst_ovf", 32'(w_ovf), 32'd0);
        chk("mrst_flag", 32'(w_flag), 32'd0);
        chk("mrst_level", 32'(w_level), 32'd0);
        chk("mrst_almost", 32'(w_almost), 32'd0);
        w_rst = 1'b0; w_inc = 1'b0;

        // Read side: remote at binary 3 (Gray 00010)
        r_rgray = 5'b00010;
        tick();
        chk("emp_flag_clear", 32'(r_flag), 32'd0);
        chk("emp_level3", 32'(r_level), 32'd3);
        chk("emp_almost3", 32'(r_almost), 32'd0);
        r_inc = 1'b1;
        tick();
        chk("emp_ptr1", 32'(r_ptr_bin), 32'd1);
        chk("emp_level2", 32'(r_level), 32'd2);
        chk("emp_almost2", 32'(r_almost), 32'd1);
        chk("emp_flag1", 32'(r_flag), 32'd0);
        tick();
        chk("emp_flag2", 32'(r_flag), 32'd0);
        tick();
        chk("emp_ptr3", 32'(r_ptr_bin), 32'd3);
        chk("emp_flag3", 32'(r_flag), 32'd1);
        chk("emp_level0", 32'(r_level), 32'd0);
        tick();
        chk("emp_blk_ptr", 32'(r_ptr_bin), 32'd3);
        chk("emp_blk_ovf", 32'(r_ovf), 32'd1);
        r_inc = 1'b0;

        // Read side wrap: reach 31, then advance across the wrap
        r_rst = 1'b1;
        tick();
        chk("rrst_flag", 32'(r_flag), 32'd1);
        chk("rrst_ovf", 32'(r_ovf), 32'd0);
        r_rst = 1'b0;
        r_rgray = 5'b11000;
        tick();
        chk("wrap_flag_clear", 32'(r_flag), 32'd0);
        r_inc = 1'b1;
        repeat (15) tick();
        chk("wrap_ptr15", 32'(r_ptr_bin), 32'd15);
        r_rgray = 5'b00011;
        repeat (16) tick();
        chk("wrap_ptr31", 32'(r_ptr_bin), 32'd31);
        chk("wrap_gray31", 32'(r_ptr_gray), 32'b10000);
        chk("wrap_flag31", 32'(r_flag), 32'd0);
        tick();
        chk("wrap_ptr0", 32'(r_ptr_bin), 32'd0);
        chk("wrap_gray0", 32'(r_ptr_gray), 32'b00000);
        chk("wrap_flag0", 32'(r_flag), 32'd0);
        // Remote changes on the same edge as an advance: judged on new pointer
        r_rgray = 5'b00001;
        tick();
        chk("same_ptr1", 32'(r_ptr_bin), 32'd1);
        chk("same_gray1", 32'(r_ptr_gray), 32'b00001);
        chk("same_flag", 32'(r_flag), 32'd1);
        r_inc = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
